// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, cent values, default diameters, frame width and tx FSM states.
// Pure declarations: no latency, no flow control.
package vend_pkg;

    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        COIN_P = 2'd0,
        COIN_N = 2'd1,
        COIN_D = 2'd2,
        COIN_Q = 2'd3
    } coin_t;

    localparam logic [7:0] CENTS_P = 8'd1;
    localparam logic [7:0] CENTS_N = 8'd5;
    localparam logic [7:0] CENTS_D = 8'd10;
    localparam logic [7:0] CENTS_Q = 8'd25;

    // Diameters in 0.001 inch units
    localparam logic [9:0] DIA_Q_DEF = 10'd955;
    localparam logic [9:0] DIA_D_DEF = 10'd705;
    localparam logic [9:0] DIA_N_DEF = 10'd835;
    localparam logic [9:0] DIA_P_DEF = 10'd750;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } tx_state_t;

    // Greedy choice; only meaningful when rem != 0
    function automatic coin_t pick_coin(input logic [7:0] rem);
        if (rem >= CENTS_Q)      return COIN_Q;
        else if (rem >= CENTS_D) return COIN_D;
        else if (rem >= CENTS_N) return COIN_N;
        else                     return COIN_P;
    endfunction

    function automatic logic [7:0] coin_cents(input coin_t c);
        case (c)
            COIN_Q:  return CENTS_Q;
            COIN_D:  return CENTS_D;
            COIN_N:  return CENTS_N;
            default: return CENTS_P;
        endcase
    endfunction

endpackage

// File: rtl/coin_frame_shifter.sv
// 10-bit PISO, MSB first: frame bit 9 appears the cycle after load, last_bit flags bit 0.
// No backpressure; shifts whenever shift_en is high during an active frame.
module coin_frame_shifter
    import vend_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [FRAME_BITS-1:0] din,
    output logic                  serial,
    output logic                  active,
    output logic                  last_bit
);

    logic [FRAME_BITS-1:0] sreg;
    logic [3:0]            bit_cnt;

    // Zero fill means the register is empty after a full frame, so serial idles low
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg    <= '0;
            bit_cnt <= 4'd0;
            active  <= 1'b0;
        end else if (load) begin
            sreg    <= din;
            bit_cnt <= 4'd0;
            active  <= 1'b1;
        end else if (shift_en && active) begin
            sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
            if (last_bit) begin
                active  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    assign serial   = sreg[FRAME_BITS-1];
    assign last_bit = active && (bit_cnt == 4'(FRAME_BITS - 1));

endmodule

// File: rtl/coin_change_tx.sv
// Change-return transmitter: splits amount greedily into coins and sends one diameter frame per coin.
// Done lands 2 + K*(11+GAP_CYC) cycles after start; start is ignored (not queued) while busy.
module coin_change_tx
    import vend_pkg::*;
#(
    parameter int         GAP_CYC = 4,
    parameter logic [9:0] DIA_Q   = DIA_Q_DEF,
    parameter logic [9:0] DIA_D   = DIA_D_DEF,
    parameter logic [9:0] DIA_N   = DIA_N_DEF,
    parameter logic [9:0] DIA_P   = DIA_P_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    output logic       busy,
    output logic       done,
    output logic       serialOut,
    output logic       enable,
    output logic [1:0] coin_type,
    output logic [3:0] coin_cnt
);

    localparam int             GW       = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYC - 1);

    tx_state_t       state, state_nxt;
    logic [7:0]      rem;
    logic [GW-1:0]   gap_cnt;
    coin_t           coin_sel;
    logic [9:0]      dia_sel;
    logic            load, shift_en, last_bit;
    logic            busy_d, done_d;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SELECT;
            ST_SELECT: state_nxt = (rem == 8'd0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT:  if (last_bit) state_nxt = ST_GAP;
            ST_GAP:    if (gap_cnt == GAP_LAST) state_nxt = ST_SELECT;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        busy_d   = (state_nxt != ST_IDLE);
        done_d   = (state_nxt == ST_DONE);
        load     = (state == ST_SELECT) && (rem != 8'd0);
        shift_en = (state == ST_SHIFT);
    end

    always_comb begin
        coin_sel = pick_coin(rem);
        case (coin_sel)
            COIN_Q:  dia_sel = DIA_Q;
            COIN_D:  dia_sel = DIA_D;
            COIN_N:  dia_sel = DIA_N;
            default: dia_sel = DIA_P;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem       <= 8'd0;
            gap_cnt   <= '0;
            coin_type <= 2'd0;
            coin_cnt  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (state == ST_IDLE && start) begin
                rem      <= amount;
                coin_cnt <= 4'd0;
            end
            if (load) begin
                rem       <= rem - coin_cents(coin_sel);
                coin_type <= coin_sel;
                coin_cnt  <= coin_cnt + 4'd1;
            end
            if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                 gap_cnt <= '0;
        end
    end

    coin_frame_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .din      (dia_sel),
        .serial   (serialOut),
        .active   (enable),
        .last_bit (last_bit)
    );

endmodule

// File: tb/tb_coin_change_tx.sv
// Bench for coin_change_tx: decodes frames like the receiving coin sensor and checks them
// against a greedy change model built with plain division.
module tb_coin_change_tx;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       busy, done, serialOut, enable;
    logic [1:0] coin_type;
    logic [3:0] coin_cnt;

    int checks = 0;
    int failures = 0;

    coin_change_tx #(.GAP_CYC(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .amount    (amount),
        .busy      (busy),
        .done      (done),
        .serialOut (serialOut),
        .enable    (enable),
        .coin_type (coin_type),
        .coin_cnt  (coin_cnt)
    );

    always #5 clk = ~clk;

    int dia_of[4]   = '{750, 835, 705, 955};
    int cents_of[4] = '{1, 5, 10, 25};

    int got_dia[$];
    int got_type[$];
    int exp_type[$];
    int done_at, done_pulses, cnt_at_done, type_at_done, first_en;
    int leak, frag, busy_bad;

    typedef struct {
        int amt;
        int exp_k;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic build_expect(input int amt);
        int r;
        exp_type.delete();
        r = amt;
        repeat (r / 25) exp_type.push_back(3);
        r = r % 25;
        repeat (r / 10) exp_type.push_back(2);
        r = r % 10;
        repeat (r / 5) exp_type.push_back(1);
        r = r % 5;
        repeat (r) exp_type.push_back(0);
    endtask

    // Runs one transaction; optionally pulses start (amount 7) at sample cycle pulse_at.
    task automatic run_txn(input int amt, input int pulse_at);
        int bitpos;
        int sh;
        int cur_type;
        got_dia.delete();
        got_type.delete();
        done_at = -1; done_pulses = 0; cnt_at_done = -1; type_at_done = -1;
        first_en = -1; leak = 0; frag = 0; busy_bad = 0;
        bitpos = 0; sh = 0; cur_type = 0;
        @(negedge clk);
        start = 1'b1;
        amount = amt[7:0];
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (serialOut && !enable) leak++;
            if (enable) begin
                if (first_en < 0) first_en = c;
                if (bitpos == 0) cur_type = int'(coin_type);
                sh = ((sh << 1) | int'(serialOut)) & 10'h3ff;
                bitpos++;
                if (bitpos == 10) begin
                    got_dia.push_back(sh);
                    got_type.push_back(cur_type);
                    bitpos = 0;
                end
            end else if (bitpos != 0) begin
                frag++;
                bitpos = 0;
            end
            if (done) begin
                done_pulses++;
                if (done_at < 0) begin
                    done_at = c;
                    cnt_at_done = int'(coin_cnt);
                    type_at_done = int'(coin_type);
                    if (!busy) busy_bad++;
                end
            end else if (done_at < 0 && !busy) begin
                busy_bad++;
            end
            if (done_at >= 0 && c == done_at + 1) begin
                if (busy) busy_bad++;
                break;
            end
            if (c == pulse_at) begin
                start = 1'b1;
                amount = 8'd7;
            end else if (c == pulse_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic compare_txn(input string tag, input int amt);
        int k, n, credit;
        build_expect(amt);
        k = exp_type.size();
        chk({tag, "_frames"}, got_dia.size(), k);
        n = (got_dia.size() < k) ? got_dia.size() : k;
        credit = 0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_dia%0d", tag, i), got_dia[i], dia_of[exp_type[i]]);
            chk($sformatf("%s_type%0d", tag, i), got_type[i], exp_type[i]);
        end
        foreach (got_type[i]) credit += cents_of[got_type[i] & 3];
        chk({tag, "_credit"}, credit, amt);
        chk({tag, "_done_cyc"}, done_at, 2 + k * (11 + GAP));
        chk({tag, "_done_pulses"}, done_pulses, 1);
        chk({tag, "_coin_cnt"}, cnt_at_done, k);
        if (k > 0) begin
            chk({tag, "_last_type"}, type_at_done, exp_type[k-1]);
            chk({tag, "_first_en"}, first_en, 2);
        end else begin
            chk({tag, "_no_enable"}, first_en, -1);
        end
        chk({tag, "_leak"}, leak, 0);
        chk({tag, "_frag"}, frag, 0);
        chk({tag, "_busy"}, busy_bad, 0);
    endtask

    initial begin
        vec_t vecs[8];
        int busy_mask, done_mask, extra, en_seen;

        vecs[0] = '{41, 4, 62};
        vecs[1] = '{0, 0, 2};
        vecs[2] = '{255, 11, 167};
        vecs[3] = '{66, 5, 77};
        vecs[4] = '{30, 2, 32};
        vecs[5] = '{99, 9, 137};
        vecs[6] = '{4, 4, 62};
        vecs[7] = '{5, 1, 17};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({busy, done, serialOut, enable, coin_type, coin_cnt}), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs", int'({busy, done, serialOut, enable, coin_type, coin_cnt}), 0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].amt, -1);
            chk($sformatf("vec%0d_k", i), got_dia.size(), vecs[i].exp_k);
            chk($sformatf("vec%0d_done", i), done_at, vecs[i].exp_done);
            compare_txn($sformatf("vec%0d", i), vecs[i].amt);
        end

        // start pulsed mid-frame must be ignored
        run_txn(41, 5);
        compare_txn("ignore_start", 41);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || enable) extra++;
        end
        chk("ignore_start_no_followup", extra, 0);

        // reset on the 5th SHIFT cycle truncates the frame
        @(negedge clk);
        start = 1'b1;
        amount = 8'd30;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_enable_before", int'(enable), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_outputs", int'({busy, done, serialOut, enable, coin_type, coin_cnt}), 0);
        extra = 0;
        en_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
            if (enable || busy) en_seen++;
        end
        chk("rst_mid_no_done", extra, 0);
        chk("rst_mid_quiet", en_seen, 0);
        run_txn(5, -1);
        compare_txn("after_rst", 5);

        // start held high: back-to-back transactions one IDLE cycle apart
        @(negedge clk);
        start = 1'b1;
        amount = 8'd0;
        busy_mask = 0;
        done_mask = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (busy) busy_mask |= (1 << (c - 1));
            if (done) done_mask |= (1 << (c - 1));
        end
        start = 1'b0;
        chk("held_start_done", done_mask, 6'b010010);
        chk("held_start_busy", busy_mask, 6'b011011);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            int a;
            a = int'($urandom_range(0, 255));
            run_txn(a, -1);
            compare_txn($sformatf("rnd%0d_a%0d", i, a), a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
